// File: rtl/mole_pkg.sv
// Shared types and default constants for the mole position sequencer.
package mole_pkg;

  typedef enum logic [1:0] {
    MODE_FWD     = 2'd0,
    MODE_REV     = 2'd1,
    MODE_RAND    = 2'd2,
    MODE_RAND_NR = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE,
    ST_GEN
  } state_e;

  localparam logic [7:0] DEFAULT_TAPS = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'h01;

endpackage

// File: rtl/mole_pos_sequencer_lfsr.sv
// Galois LFSR with synchronous reset, load (zero seed replaced by SEED) and step.
module mole_lfsr
  import mole_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED),
  parameter int unsigned      OUT_W = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [OUT_W-1:0] value
);

  logic [WIDTH-1:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (load) begin
      // An all-zero state would lock the register, so substitute the reset seed.
      lfsr_q <= (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/mole_pos_sequencer.sv
// Next-mole-position generator: walk or LFSR-random modes with bounded retries.
// Optional MOLE_LAST2_EN: no-repeat mode also avoids the position before last.
module mole_pos_sequencer
  import mole_pkg::*;
#(
  parameter int unsigned      NUM_HOLES = 8,
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(DEFAULT_SEED),
  parameter int unsigned      MAX_TRIES = 16,
  parameter int unsigned      CNT_W     = 8,
  localparam int unsigned     POS_W     = ($clog2(NUM_HOLES) > 1) ? $clog2(NUM_HOLES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [1:0]       mode,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [POS_W-1:0] pos,
  output logic             valid,
  output logic             busy,
  output logic             fallback,
  output logic [CNT_W-1:0] round_cnt
);

  localparam int unsigned      TRY_W     = ($clog2(MAX_TRIES + 1) > 1) ? $clog2(MAX_TRIES + 1) : 1;
  localparam logic [POS_W-1:0] LAST_HOLE = POS_W'(NUM_HOLES - 1);
  localparam logic [POS_W:0]   HOLES_EXT = (POS_W + 1)'(NUM_HOLES);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             valid_q, valid_d;
  logic             fallback_q, fallback_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] cand, fwd, fwd2, rev, fb_pos;
  logic             lfsr_step, cand_ok, emit;

`ifdef MOLE_LAST2_EN
  logic [POS_W-1:0] prev_pos_q, prev_pos_d;
  if (NUM_HOLES < 3) begin : g_holes_check
    $error("MOLE_LAST2_EN requires NUM_HOLES >= 3");
  end
`endif

  mole_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED),
    .OUT_W (POS_W)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .step     (lfsr_step),
    .load     (seed_load),
    .load_val (seed),
    .value    (cand)
  );

  assign fwd  = (pos_q == LAST_HOLE) ? '0 : pos_q + POS_W'(1);
  assign fwd2 = (fwd == LAST_HOLE) ? '0 : fwd + POS_W'(1);
  assign rev  = (pos_q == '0) ? LAST_HOLE : pos_q - POS_W'(1);

  always_comb begin
    cand_ok = ({1'b0, cand} < HOLES_EXT);
    fb_pos  = fwd;
    if (mode_q == MODE_RAND_NR) begin
      cand_ok = cand_ok && (cand != pos_q);
`ifdef MOLE_LAST2_EN
      cand_ok = cand_ok && (cand != prev_pos_q);
      // Two steps always clear both pos and prev_pos when NUM_HOLES >= 3.
      if (fwd == prev_pos_q) fb_pos = fwd2;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tries_d    = tries_q;
    pos_d      = pos_q;
    valid_d    = 1'b0;
    fallback_d = fallback_q;
    cnt_d      = cnt_q;
    lfsr_step  = 1'b0;
    emit       = 1'b0;
`ifdef MOLE_LAST2_EN
    prev_pos_d = prev_pos_q;
`endif
    if (seed_load) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req) begin
            state_d    = ST_GEN;
            mode_d     = mode_e'(mode);
            tries_d    = '0;
            fallback_d = 1'b0;
          end
        end
        ST_GEN: begin
          if (mode_q inside {MODE_RAND, MODE_RAND_NR} && tries_q == TRY_W'(MAX_TRIES)) begin
            pos_d      = fb_pos;
            fallback_d = 1'b1;
            emit       = 1'b1;
          end else begin
            unique case (mode_q)
              MODE_FWD: begin pos_d = fwd; emit = 1'b1; end
              MODE_REV: begin pos_d = rev; emit = 1'b1; end
              default: begin
                lfsr_step = 1'b1;
                if (cand_ok) begin
                  pos_d = cand;
                  emit  = 1'b1;
                end else begin
                  tries_d = tries_q + TRY_W'(1);
                end
              end
            endcase
          end
          if (emit) begin
            state_d = ST_IDLE;
            valid_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
`ifdef MOLE_LAST2_EN
            prev_pos_d = pos_q;
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_FWD;
      tries_q    <= '0;
      pos_q      <= '0;
      valid_q    <= 1'b0;
      fallback_q <= 1'b0;
      cnt_q      <= '0;
`ifdef MOLE_LAST2_EN
      prev_pos_q <= '0;
`endif
    end else begin
      mode_q     <= mode_d;
      tries_q    <= tries_d;
      pos_q      <= pos_d;
      valid_q    <= valid_d;
      fallback_q <= fallback_d;
      cnt_q      <= cnt_d;
`ifdef MOLE_LAST2_EN
      prev_pos_q <= prev_pos_d;
`endif
    end
  end

  always_comb begin
    busy      = (state_q == ST_GEN);
    pos       = pos_q;
    valid     = valid_q;
    fallback  = fallback_q;
    round_cnt = cnt_q;
  end

endmodule
